// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the CPU/loader memory port arbiter.
// Holds the owner-state enum, port IDs and bus widths.
package mem_port_arbiter_pkg;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 16;
    localparam int BURST_MAX = 16;
    localparam int CNT_W     = $clog2(BURST_MAX + 1);

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        CPU_OWN,
        LDR_OWN
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_burst_counter.sv
// Saturating count of loader grants taken while the CPU waits.
// Clear has priority over increment.
module arb_burst_counter
    import mem_port_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    // count loader grants, stopping at BURST_MAX
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && cnt != CNT_W'(BURST_MAX))
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (CPU, loader) single-memory arbiter with loader burst lock.
// Grant and memory command are combinational; read-valid follows by one cycle.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    input  logic              ldr_lock,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    owner_t            owner;
    owner_t            owner_nxt;
    logic [CNT_W-1:0]  burst_cnt;
    logic              burst_sat;
    logic              port_sel;
    logic              any_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    assign burst_sat = (burst_cnt == CNT_W'(BURST_MAX));

    arb_burst_counter u_burst (
        .clk   (clk),
        .reset (reset),
        .inc   (ldr_gnt & cpu_req),
        .clr   (cpu_gnt | ~cpu_req),
        .cnt   (burst_cnt)
    );

    // owner register: port granted in the previous cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            owner <= IDLE;
        else
            owner <= owner_nxt;
    end

    // arbitration and next owner
    always_comb begin
        cpu_gnt   = 1'b0;
        ldr_gnt   = 1'b0;
        owner_nxt = IDLE;
        if (!reset) begin
            if (cpu_req && ldr_req) begin
                if (owner == LDR_OWN && ldr_lock && !burst_sat)
                    ldr_gnt = 1'b1;
                else if (owner == CPU_OWN)
                    ldr_gnt = 1'b1;
                else
                    cpu_gnt = 1'b1;
            end else begin
                cpu_gnt = cpu_req;
                ldr_gnt = ldr_req;
            end
        end
        if (cpu_gnt)
            owner_nxt = CPU_OWN;
        else if (ldr_gnt)
            owner_nxt = LDR_OWN;
    end

    assign cpu_stall = cpu_req & ~cpu_gnt & ~reset;
    assign any_gnt   = cpu_gnt | ldr_gnt;
    assign port_sel  = ldr_gnt ? PORT_LDR : PORT_CPU;
    assign sel_we    = (port_sel == PORT_LDR) ? ldr_we : cpu_we;

    // memory command mux; address and data hold when idle
    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        if (any_gnt) begin
            mem_rd = ~sel_we;
            mem_wr = sel_we;
            if (port_sel == PORT_LDR) begin
                mem_addr  = ldr_addr;
                mem_wdata = ldr_wdata;
            end else begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
        end
    end

    // last driven address/data and one-cycle read-valid flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            cpu_rvalid <= 1'b0;
            ldr_rvalid <= 1'b0;
        end else begin
            addr_q     <= mem_addr;
            wdata_q    <= mem_wdata;
            cpu_rvalid <= cpu_gnt & ~cpu_we;
            ldr_rvalid <= ldr_gnt & ~ldr_we;
        end
    end

    assign rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed
// sequences and random traffic against a reference model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock;
    logic [11:0] cpu_addr, ldr_addr, mem_addr;
    logic [15:0] cpu_wdata, ldr_wdata, mem_wdata, mem_rdata, rdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid, ldr_gnt, ldr_rvalid;
    logic        mem_rd, mem_wr;

    int tests = 0;
    int fails = 0;

    mem_port_arbiter u_dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .ldr_req    (ldr_req),
        .ldr_we     (ldr_we),
        .ldr_addr   (ldr_addr),
        .ldr_wdata  (ldr_wdata),
        .ldr_lock   (ldr_lock),
        .ldr_gnt    (ldr_gnt),
        .ldr_rvalid (ldr_rvalid),
        .rdata      (rdata),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // memory: synchronous write, read data registered one cycle after mem_rd
    logic [15:0] mem [0:4095];
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    // reference model state
    logic [15:0] ref_mem [0:4095];
    bit          written [0:4095];
    int          m_last;      // 0 none, 1 cpu, 2 loader
    int          m_run;       // loader grants in a row with CPU waiting
    bit          m_cpu_rv, m_ldr_rv, m_rd_known, m_addr_known;
    logic [15:0] m_rdata, m_wd;
    logic [11:0] m_addr;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_last = 0; m_run = 0;
        m_cpu_rv = 0; m_ldr_rv = 0;
        m_rd_known = 0; m_addr_known = 0;
    endtask

    // drive one cycle's inputs, check DUT against model, advance model
    task automatic apply(input bit cr, input bit cw, input logic [11:0] ca,
                         input logic [15:0] cd, input bit lr, input bit lw,
                         input logic [11:0] la, input logic [15:0] ld,
                         input bit lk);
        bit eg_c, eg_l, e_rd, e_wr;
        logic [11:0] e_addr;
        logic [15:0] e_wd;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        ldr_req = lr; ldr_we = lw; ldr_addr = la; ldr_wdata = ld;
        ldr_lock = lk;
        #1;
        chk("m_cpu_rvalid", cpu_rvalid, m_cpu_rv);
        chk("m_ldr_rvalid", ldr_rvalid, m_ldr_rv);
        if ((m_cpu_rv || m_ldr_rv) && m_rd_known)
            chk("m_rdata", rdata, m_rdata);
        eg_c = 0; eg_l = 0;
        if (cr && !lr) eg_c = 1;
        else if (lr && !cr) eg_l = 1;
        else if (cr && lr) begin
            if (m_last == 2 && lk && m_run < 16) eg_l = 1;
            else if (m_last == 1) eg_l = 1;
            else eg_c = 1;
        end
        chk("m_grants", {cpu_gnt, ldr_gnt, cpu_stall},
            {eg_c, eg_l, cr && !eg_c});
        e_addr = eg_c ? ca : (eg_l ? la : m_addr);
        e_wd   = eg_c ? cd : (eg_l ? ld : m_wd);
        e_rd   = (eg_c && !cw) || (eg_l && !lw);
        e_wr   = (eg_c && cw) || (eg_l && lw);
        chk("m_strobes", {mem_rd, mem_wr}, {e_rd, e_wr});
        if (eg_c || eg_l || m_addr_known) begin
            chk("m_addr", mem_addr, e_addr);
            chk("m_wdata", mem_wdata, e_wd);
        end
        if (eg_c || eg_l) m_addr_known = 1;
        m_addr = e_addr; m_wd = e_wd;
        m_cpu_rv = eg_c && !cw;
        m_ldr_rv = eg_l && !lw;
        if (e_rd) begin
            m_rd_known = written[e_addr];
            m_rdata    = ref_mem[e_addr];
        end
        if (e_wr) begin
            ref_mem[e_addr] = e_wd;
            written[e_addr] = 1;
        end
        m_last = eg_c ? 1 : (eg_l ? 2 : 0);
        if (!cr || eg_c) m_run = 0;
        else if (eg_l) m_run = (m_run < 16) ? m_run + 1 : 16;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_outputs", {cpu_gnt, ldr_gnt, cpu_stall, mem_rd, mem_wr},
            5'b0);
        @(negedge clk);
        chk("rst_rvalid", {cpu_rvalid, ldr_rvalid}, 2'b0);
        chk("rst_burst_cnt", u_dut.burst_cnt, 0);
        reset = 1'b0;
    endtask

    typedef struct {
        bit       cr, lr, lk;
        bit [2:0] exp;   // {cpu_gnt, ldr_gnt, cpu_stall}
    } vec_t;
    vec_t tbl [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  run;
        bit  got_cpu;
        tbl[0] = '{1, 0, 0, 3'b100};
        tbl[1] = '{1, 1, 0, 3'b011};
        tbl[2] = '{1, 1, 0, 3'b100};
        tbl[3] = '{1, 1, 1, 3'b011};
        tbl[4] = '{1, 1, 1, 3'b011};
        tbl[5] = '{1, 1, 0, 3'b100};
        tbl[6] = '{0, 0, 0, 3'b000};
        tbl[7] = '{1, 1, 1, 3'b100};
        tbl[8] = '{0, 1, 1, 3'b010};
        tbl[9] = '{0, 0, 0, 3'b000};

        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
        ldr_lock = 0;
        model_reset();
        repeat (2) @(negedge clk);
        cpu_req = 1; ldr_req = 1;
        #1;
        chk("reset_state",
            {cpu_gnt, ldr_gnt, cpu_stall, mem_rd, mem_wr, cpu_rvalid,
             ldr_rvalid}, 7'b0);
        chk("reset_burst_cnt", u_dut.burst_cnt, 0);
        @(negedge clk);
        reset = 1'b0;

        // vector table, starting from IDLE
        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].cr, 0, 12'(i), 16'(i), tbl[i].lr, 1,
                  12'(i + 32), 16'(i * 3), tbl[i].lk);
            chk($sformatf("tbl%0d", i), {cpu_gnt, ldr_gnt, cpu_stall},
                tbl[i].exp);
            @(negedge clk);
        end

        // CPU read returns stored data one cycle later
        apply(1, 1, 12'h010, 16'h1234, 0, 0, 0, 0, 0);
        @(negedge clk);
        apply(1, 0, 12'h010, 0, 0, 0, 0, 0, 0);
        chk("rd_gnt", {cpu_gnt, mem_rd, mem_wr}, 3'b110);
        chk("rd_addr", mem_addr, 12'h010);
        @(negedge clk);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rd_rvalid", {cpu_rvalid, ldr_rvalid}, 2'b10);
        chk("rd_data", rdata, 16'h1234);
        @(negedge clk);

        // alternation without lock
        for (int i = 0; i < 4; i++) begin
            apply(1, 0, 12'h1, 0, 1, 0, 12'h2, 0, 0);
            chk($sformatf("alt%0d", i), {cpu_gnt, ldr_gnt, cpu_stall},
                (i % 2 == 0) ? 3'b100 : 3'b011);
            @(negedge clk);
        end
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        // locked burst: loader owns first, then CPU waits
        apply(0, 0, 0, 0, 1, 0, 12'h40, 0, 1);
        @(negedge clk);
        run = 0; got_cpu = 0;
        for (int i = 0; i < 40; i++) begin
            apply(1, 0, 12'h5, 0, 1, 0, 12'(i + 64), 0, 1);
            if (cpu_gnt) begin
                got_cpu = 1;
                break;
            end
            if (ldr_gnt) run++;
            @(negedge clk);
        end
        chk("burst_cpu_granted", got_cpu, 1);
        chk("burst_len", run, 16);
        chk("burst_sat_before_cpu", u_dut.burst_cnt, 16);
        @(negedge clk);
        chk("burst_cnt_cleared", u_dut.burst_cnt, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        // loader write then CPU read of the same word
        apply(0, 0, 0, 0, 1, 1, 12'h0FF, 16'hBEEF, 0);
        chk("lw_gnt", {ldr_gnt, mem_wr, mem_rd}, 3'b110);
        chk("lw_addr", mem_addr, 12'h0FF);
        chk("lw_data", mem_wdata, 16'hBEEF);
        @(negedge clk);
        chk("lw_no_rvalid", {cpu_rvalid, ldr_rvalid}, 2'b00);
        apply(1, 0, 12'h0FF, 0, 0, 0, 0, 0, 0);
        chk("cr_gnt", {cpu_gnt, mem_rd}, 2'b11);
        @(negedge clk);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("cr_rvalid", {cpu_rvalid, ldr_rvalid}, 2'b10);
        chk("cr_data", rdata, 16'hBEEF);
        chk("hold_addr", mem_addr, 12'h0FF);
        @(negedge clk);

        // reset during a granted read discards the rvalid
        apply(1, 0, 12'h0FF, 0, 0, 0, 0, 0, 0);
        do_reset();
        apply(1, 0, 12'h3, 0, 1, 0, 12'h4, 0, 1);
        chk("post_rst_cpu_first", {cpu_gnt, ldr_gnt}, 2'b10);
        @(negedge clk);

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            apply($urandom_range(0, 9) < 7, $urandom_range(0, 1),
                  12'($urandom_range(0, 15)), 16'($urandom),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 1),
                  12'($urandom_range(0, 15)), 16'($urandom),
                  $urandom_range(0, 9) < 8);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 BURST_MAX, 16, maximum consecutive loader grants while the CPU is waiting.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cpu_req  input  1  CPU requests a memory access this cycle.
REQ-005 cpu_we  input  1  CPU access is a write (1) or a read (0).
REQ-006 cpu_addr  input  12  CPU word address.
REQ-007 cpu_wdata  input  16  CPU write data.
REQ-008 cpu_gnt  output  1  CPU access accepted this cycle.
REQ-009 cpu_stall  output  1  cpu_req high and cpu_gnt low; the CPU holds its state.
REQ-010 cpu_rvalid  output  1  read data for the CPU is valid on rdata.
REQ-011 ldr_req, ldr_we, ldr_addr, ldr_wdata  input  1/1/12/16  loader port, same meaning as the CPU port.
REQ-012 ldr_lock  input  1  loader asks to keep ownership for a burst.
REQ-013 ldr_gnt, ldr_rvalid  output  1/1  loader grant and loader read-valid.
REQ-014 rdata  output  16  shared read data, equal to mem_rdata.
REQ-015 mem_rd, mem_wr  output  1/1  memory read and write strobes.
REQ-016 mem_addr, mem_wdata  output  12/16  memory address and write data.
REQ-017 mem_rdata  input  16  memory read data, valid the cycle after mem_rd.

Function
REQ-018 The block SHALL grant at most one port per cycle; grant is combinational from the current requests and registered state, with the memory command driven in the same cycle.
REQ-019 The owner state SHALL be one of IDLE, CPU_OWN or LDR_OWN, holding the port granted in the previous cycle (IDLE if none).
REQ-020 Only one port requesting: that port SHALL be granted.
REQ-021 Both requesting, owner LDR_OWN, ldr_lock=1 and burst_cnt<BURST_MAX: the loader SHALL be granted.
REQ-022 Both requesting in any other case: the port not granted last SHALL be granted, with the CPU winning from IDLE.
REQ-023 burst_cnt SHALL increment on each loader grant while cpu_req=1, and SHALL clear on a CPU grant or when cpu_req=0; it SHALL saturate at BURST_MAX and be $clog2(BURST_MAX+1) bits wide.
REQ-024 Granted port: mem_addr and mem_wdata SHALL mux from that port; mem_wr=we and mem_rd=~we.
REQ-025 No grant: mem_rd=mem_wr=0, while mem_addr and mem_wdata hold their last values.
REQ-026 A granted read SHALL assert the matching *_rvalid for exactly one cycle, in the following cycle; writes produce no rvalid.
REQ-027 A grant in cycle N+1 SHALL be allowed while the rvalid from cycle N is presented, giving full throughput.
REQ-028 Dropping ldr_lock SHALL take effect in the same cycle's arbitration.

Reset
REQ-029 While reset is high, the owner SHALL be IDLE, burst_cnt=0, both rvalid flags 0, and all grants, cpu_stall, mem_rd and mem_wr 0.
REQ-030 Reset asserted mid-access SHALL discard any pending rvalid; the first cycle after release SHALL arbitrate from IDLE.

Structure
REQ-031 A shared package SHALL hold the owner-state enum (IDLE, CPU_OWN, LDR_OWN), the port-ID constants and the ADDR_W=12 and DATA_W=16 constants.
REQ-032 One sub-module, arb_burst_counter, SHALL implement the saturating burst counter; the remaining logic SHALL stay flat.

Verification
REQ-033 CPU read only of addr 0x010, memory holding 0x1234 -> cpu_gnt in the same cycle, mem_rd=1, and the next cycle cpu_rvalid=1 with rdata=0x1234.
REQ-034 Both requesting continuously, ldr_lock=0 -> grants alternate CPU, LDR, CPU, LDR, with cpu_stall high on every loader cycle.
REQ-035 Both requesting, ldr_lock=1, loader owning first -> exactly 16 consecutive loader grants, then a CPU grant, then burst_cnt=0.
REQ-036 Loader write of 0xBEEF to 0x0FF, then CPU read of 0x0FF -> mem_wr pulse with the correct data, then cpu_rvalid with rdata=0xBEEF and no ldr_rvalid.
REQ-037 Reset asserted the cycle after a granted read -> no rvalid asserted; after release with both requesting, the CPU is granted first.
